// File: rtl/ram_256b_pkg.sv
// Shared definitions for the data memory and the control unit:
// opcode encodings, handshake FSM states and opcode classifiers.
package ram_256b_pkg;

  localparam logic [5:0] OP_LDUB = 6'h01;
  localparam logic [5:0] OP_LDSB = 6'h09;
  localparam logic [5:0] OP_LDUH = 6'h02;
  localparam logic [5:0] OP_LDSH = 6'h0A;
  localparam logic [5:0] OP_LDW  = 6'h08;
  localparam logic [5:0] OP_STB  = 6'h05;
  localparam logic [5:0] OP_STH  = 6'h06;
  localparam logic [5:0] OP_STW  = 6'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // True for any of the five load opcodes.
  function automatic logic is_load(input logic [5:0] op);
    logic r;
    case (op)
      OP_LDUB, OP_LDSB, OP_LDUH, OP_LDSH, OP_LDW: r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_256b_ext.sv
// Load lane selection and zero/sign extension. The four bytes arrive in
// big-endian order starting at the access address (b0 = most significant).
module ram_256b_ext
  import ram_256b_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  output logic [31:0] load_data,
  output logic        load_valid
);

  // Build the 32-bit load result for the current opcode.
  always_comb begin
    load_data  = 32'h0000_0000;
    load_valid = is_load(op);
    case (op)
      OP_LDUB: load_data = {24'h00_0000, b0};
      OP_LDSB: load_data = {{24{b0[7]}}, b0};
      OP_LDUH: load_data = {16'h0000, b0, b1};
      OP_LDSH: load_data = {{16{b0[7]}}, b0, b1};
      OP_LDW:  load_data = {b0, b1, b2, b3};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ram_256b.sv
// 256-byte big-endian data memory with the MFA/MFC handshake.
// The request is latched when accepted; the access itself happens on the
// edge that enters DONE, so a store commits exactly once per request.
module ram_256b
  import ram_256b_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MFA,
  input  logic [5:0]  opcode,
  input  logic [7:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MFC
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [7:0]  ram [0:255];

  mem_state_t  state_r;
  logic [CW-1:0] cnt_r;
  logic [5:0]  op_r;
  logic [7:0]  addr_r;
  logic [31:0] din_r;

  logic [7:0]  addr1_s;
  logic [7:0]  addr2_s;
  logic [7:0]  addr3_s;
  logic        commit_s;
  logic [31:0] load_data_s;
  logic        load_valid_s;

  // Byte addresses of the access (mod 256) and the commit strobe.
  always_comb begin
    addr1_s  = addr_r + 8'd1;
    addr2_s  = addr_r + 8'd2;
    addr3_s  = addr_r + 8'd3;
    commit_s = 1'b0;
    if ((state_r == ST_BUSY) && MFA && (cnt_r >= LAT_C) && !reset) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  ram_256b_ext u_ext (
    .op         (op_r),
    .b0         (ram[addr_r]),
    .b1         (ram[addr1_s]),
    .b2         (ram[addr2_s]),
    .b3         (ram[addr3_s]),
    .load_data  (load_data_s),
    .load_valid (load_valid_s)
  );

  // Handshake FSM: latch request, wait out the latency, complete, release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      MFC      <= 1'b0;
      data_out <= 32'h0000_0000;
      cnt_r    <= {CW{1'b0}};
      op_r     <= 6'h00;
      addr_r   <= 8'h00;
      din_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          MFC <= 1'b0;
          if (MFA) begin
            state_r <= ST_BUSY;
            op_r    <= opcode;
            addr_r  <= addr;
            din_r   <= data_in;
            cnt_r   <= ONE_C;
          end
        end
        ST_BUSY: begin
          if (!MFA) begin
            state_r <= ST_IDLE;
          end else if (cnt_r >= LAT_C) begin
            state_r <= ST_DONE;
            MFC     <= 1'b1;
            if (load_valid_s) begin
              data_out <= load_data_s;
            end
          end else begin
            cnt_r <= cnt_r + ONE_C;
          end
        end
        ST_DONE: begin
          if (!MFA) begin
            state_r <= ST_IDLE;
            MFC     <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          MFC     <= 1'b0;
        end
      endcase
    end
  end

  // Store path: writes only the addressed bytes, once, on the commit edge.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      case (op_r)
        OP_STB: begin
          ram[addr_r]  <= din_r[7:0];
        end
        OP_STH: begin
          ram[addr_r]  <= din_r[15:8];
          ram[addr1_s] <= din_r[7:0];
        end
        OP_STW: begin
          ram[addr_r]  <= din_r[31:24];
          ram[addr1_s] <= din_r[23:16];
          ram[addr2_s] <= din_r[15:8];
          ram[addr3_s] <= din_r[7:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_256b.sv
// Directed bench for ram_256b: table of accesses with expected data_out,
// plus hand-written hold, abort and reset-during-BUSY sequences.
module tb_ram_256b;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        MFA;
  logic [5:0]  opcode;
  logic [7:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MFC;

  int n_checks = 0;
  int n_fail   = 0;

  ram_256b #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MFA      (MFA),
    .opcode   (opcode),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .MFC      (MFC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  // Wait (bounded) for MFC after raising MFA; returns edges after the sampling edge.
  task automatic wait_mfc(input string name, output int lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (MFC === 1'b1) seen = 1'b1;
    end
    lat = n - 1;
    n_checks++;
    if (!seen || lat != LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (MFC seen=%0b), expected %0d", name, lat, seen, LAT);
    end
  endtask

  // Full handshake for one access, then check MFC release and data_out.
  task automatic do_access(input string name, input logic [5:0] op, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
    int lat;
    opcode  = op;
    addr    = a;
    data_in = d;
    MFA     = 1'b1;
    wait_mfc(name, lat);
    check32({name, " data_out"}, data_out, exp);
    MFA = 1'b0;
    @(posedge clk); #1;
    check1({name, " MFC release"}, MFC, 1'b0);
  endtask

  initial begin
    int lat;
    bit held_ok;

    vecs[0]  = '{6'h05, 8'h00, 32'h0000_0001, 32'h0000_0000};  // STB
    vecs[1]  = '{6'h05, 8'h01, 32'h0000_0023, 32'h0000_0000};  // STB
    vecs[2]  = '{6'h06, 8'h02, 32'h0000_4567, 32'h0000_0000};  // STH
    vecs[3]  = '{6'h04, 8'h04, 32'h123A_BCDF, 32'h0000_0000};  // STW
    vecs[4]  = '{6'h08, 8'h00, 32'hFFFF_FFFF, 32'h0123_4567};  // LDW
    vecs[5]  = '{6'h08, 8'h04, 32'h0000_0000, 32'h123A_BCDF};  // LDW
    vecs[6]  = '{6'h01, 8'h00, 32'h0000_0000, 32'h0000_0001};  // LDUB
    vecs[7]  = '{6'h01, 8'h04, 32'h0000_0000, 32'h0000_0012};  // LDUB
    vecs[8]  = '{6'h09, 8'h06, 32'h0000_0000, 32'hFFFF_FFBC};  // LDSB
    vecs[9]  = '{6'h02, 8'h03, 32'h0000_0000, 32'h0000_6712};  // LDUH unaligned
    vecs[10] = '{6'h02, 8'h06, 32'h0000_0000, 32'h0000_BCDF};  // LDUH
    vecs[11] = '{6'h0A, 8'h02, 32'h0000_0000, 32'h0000_4567};  // LDSH positive
    vecs[12] = '{6'h0A, 8'h06, 32'h0000_0000, 32'hFFFF_BCDF};  // LDSH negative
    vecs[13] = '{6'h04, 8'hFE, 32'hAABB_CCDD, 32'hFFFF_BCDF};  // STW wrap, data_out kept
    vecs[14] = '{6'h3F, 8'h00, 32'h1234_5678, 32'hFFFF_BCDF};  // illegal op, data_out kept
    vecs[15] = '{6'h08, 8'hFE, 32'h0000_0000, 32'hAABB_CCDD};  // LDW wrap
    vecs[16] = '{6'h01, 8'h00, 32'h0000_0000, 32'h0000_00CC};  // LDUB wrapped byte
    vecs[17] = '{6'h09, 8'h01, 32'h0000_0000, 32'hFFFF_FFDD};  // LDSB wrapped byte
    vecs[18] = '{6'h02, 8'hFF, 32'h0000_0000, 32'h0000_BBCC};  // LDUH across 0xFF

    reset   = 1'b1;
    MFA     = 1'b0;
    opcode  = 6'h00;
    addr    = 8'h00;
    data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check1("reset MFC", MFC, 1'b0);
    check32("reset data_out", data_out, 32'h0);

    for (int i = 0; i < 19; i++) begin
      do_access($sformatf("vec%0d op%02h@%02h", i, vecs[i].op, vecs[i].a),
                vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].exp);
    end

    // Hold MFA for 10 cycles after completion while inputs change: one write only.
    do_access("pre STB 11", 6'h05, 8'h11, 32'h0000_00EE, 32'h0000_BBCC);
    opcode  = 6'h05;
    addr    = 8'h10;
    data_in = 32'h0000_005A;
    MFA     = 1'b1;
    wait_mfc("hold STB", lat);
    addr    = 8'h11;
    data_in = 32'h0000_0077;
    opcode  = 6'h04;
    held_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (MFC !== 1'b1) held_ok = 1'b0;
    end
    check1("hold MFC stays high", held_ok, 1'b1);
    MFA = 1'b0;
    @(posedge clk); #1;
    check1("hold MFC release", MFC, 1'b0);
    do_access("hold LDUB 10", 6'h01, 8'h10, 32'h0, 32'h0000_005A);
    do_access("hold LDUB 11", 6'h01, 8'h11, 32'h0, 32'h0000_00EE);

    // Abort: MFA dropped during BUSY -> no write, no MFC.
    do_access("pre STB 20", 6'h05, 8'h20, 32'h0000_0044, 32'h0000_00EE);
    opcode  = 6'h05;
    addr    = 8'h20;
    data_in = 32'h0000_0055;
    MFA     = 1'b1;
    @(posedge clk); #1;
    MFA = 1'b0;
    held_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (MFC !== 1'b0) held_ok = 1'b0;
    end
    check1("abort MFC stays low", held_ok, 1'b1);
    do_access("abort LDUB 20", 6'h01, 8'h20, 32'h0, 32'h0000_0044);

    // Reset while BUSY: MFC low, data_out cleared, store dropped.
    opcode  = 6'h05;
    addr    = 8'h20;
    data_in = 32'h0000_0099;
    MFA     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    MFA   = 1'b0;
    check1("busy reset MFC", MFC, 1'b0);
    check32("busy reset data_out", data_out, 32'h0);
    held_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (MFC !== 1'b0) held_ok = 1'b0;
    end
    check1("busy reset no completion", held_ok, 1'b1);
    do_access("busy reset LDUB 20", 6'h01, 8'h20, 32'h0, 32'h0000_0044);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "timeout");
  end

endmodule
